button_sync_pulse: RTL and testbench
====================================

BUTTON_SYNC_PULSE -- requirements
Module: button_sync_pulse

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized cycles of a stable level required to accept a press or release; legal range 2..65535.
REQ-002 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately, independent of clk.
REQ-004 Port btn  input  1  raw, asynchronous, bouncing push-button level; 1 = pressed.
REQ-005 Port pulse  output  1  registered single-cycle strobe on each accepted press; drives the downstream counter/toggle stage's restart input.
REQ-006 Port held  output  1  registered debounced level; 1 while the press is accepted and not yet released.

Function
REQ-007 btn SHALL pass through a two-flop synchronizer; its second stage is sync_btn, and only sync_btn feeds the FSM.
REQ-008 FSM states SHALL be IDLE, ARMING, HELD, RELEASING; counter cnt is $clog2(DEBOUNCE_CYCLES) bits wide, unsigned, and never wraps.
REQ-009 IDLE: sync_btn=1 -> ARMING with cnt=1; otherwise stay, cnt=0.
REQ-010 ARMING: sync_btn=0 -> IDLE, cnt=0, no pulse; sync_btn=1 and cnt<DEBOUNCE_CYCLES-1 -> cnt+1; sync_btn=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD, cnt=0, pulse=1 for exactly that one following cycle.
REQ-011 HELD: sync_btn=0 -> RELEASING with cnt=1; otherwise stay.
REQ-012 RELEASING: sync_btn=1 -> HELD, cnt=0, no new pulse; sync_btn=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, cnt=0; otherwise cnt+1.
REQ-013 held SHALL be 1 exactly when the registered state is HELD or RELEASING.
REQ-014 Latency: with btn stable high before clock edge k, pulse SHALL be 1 in the cycle after edge k+1+DEBOUNCE_CYCLES and 0 in the cycle after that (DEBOUNCE_CYCLES=4: pulse high in the cycle following edge k+5).
REQ-015 pulse SHALL never be high for two consecutive cycles, and SHALL fire at most once per accepted press, regardless of how long btn stays high.
REQ-016 A bounce shorter than DEBOUNCE_CYCLES synchronized cycles SHALL return the FSM to its prior stable state with no change to pulse or held.

Reset
REQ-017 While rst=0: both synchronizer flops =0, state=IDLE, cnt=0, pulse=0, held=0.
REQ-018 Reset asserted mid-ARMING or mid-HELD SHALL abort without emitting pulse; after deassertion a btn that is still high SHALL be re-debounced from IDLE and produce one pulse.
REQ-019 rst deassertion SHALL take effect at the next rising clk edge; no output glitches on deassertion.

Configuration
REQ-020 Macro BTN_RELEASE_PULSE_EN defined: an extra port rel_pulse (output, 1 bit) SHALL exist, strobing 1 for exactly one cycle on each RELEASING->IDLE transition, reset value 0.
REQ-021 Macro BTN_RELEASE_PULSE_EN undefined: port rel_pulse and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-022 Shared package btn_pkg SHALL hold the state enumeration (IDLE, ARMING, HELD, RELEASING) and the default debounce constant, 4.
REQ-023 One sub-module sync2 (two-flop synchronizer, async active-low reset to 0) SHALL be instantiated for btn; the FSM, counter and output registers live in button_sync_pulse.

Verification
REQ-024 Reset: hold rst=0 for 3 cycles with btn=1 -> pulse=0, held=0 throughout; release rst -> exactly one pulse 6 edges later (DEBOUNCE_CYCLES=4).
REQ-025 Clean press: btn 0->1, held high 20 cycles -> single 1-cycle pulse at edge k+5, held=1 from that cycle; held falls 6 edges after btn returns to 0.
REQ-026 Bounce: btn high 2 cycles, low 1, high 2, low -> pulse never asserts, held stays 0, state returns to IDLE.
REQ-027 Release glitch: in HELD, drive btn low for 2 cycles then high -> held stays 1, no second pulse, no rel_pulse.
REQ-028 Mid-operation reset: assert rst at cnt=2 in ARMING -> pulse=0 immediately and stays 0; deassert with btn high -> one pulse after the full debounce latency.
REQ-029 With BTN_RELEASE_PULSE_EN defined: press then release -> one pulse on press, one rel_pulse exactly 6 edges after btn falls; without the macro the bench confirms the port is absent.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding,
// the default debounce length and a small state-decoding helper.
package btn_pkg;

  // Default number of stable synchronized cycles needed to accept a level.
  localparam int unsigned DEBOUNCE_DEFAULT = 32'd4;

  // Debouncer states; HELD and RELEASING both mean "button accepted as down".
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } btn_state_e;

  // The debounced level is high whenever a press has been accepted and its
  // release has not yet been confirmed.
  function automatic logic is_held_state(input btn_state_e s);
    return (s == HELD) || (s == RELEASING);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Both stages clear to 0 under the asynchronous active-low reset.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // Shift the raw level through two flops to resolve metastability.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_r <= 1'b0;
      q_r    <= 1'b0;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/button_sync_pulse.sv
// Push-button debouncer: synchronizes a bouncing button level, accepts a
// press or release only after DEBOUNCE_CYCLES stable synchronized cycles,
// and emits a one-cycle strobe per accepted press plus a debounced level.
// Optional build macro BTN_RELEASE_PULSE_EN adds a rel_pulse output that
// strobes once per confirmed release (RELEASING -> IDLE).
module button_sync_pulse
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
`ifdef BTN_RELEASE_PULSE_EN
  output logic rel_pulse,
`endif
  output logic pulse,
  output logic held
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  // Last count value; reaching it with the level still stable accepts it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic             sync_btn_s;
  btn_state_e       state_r;
  btn_state_e       state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             pulse_r;
  logic             pulse_s;
  logic             held_r;
  logic             held_s;
`ifdef BTN_RELEASE_PULSE_EN
  logic             rel_pulse_r;
  logic             rel_pulse_s;
`endif

  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (btn),
    .q   (sync_btn_s)
  );

  // Next-state, stability counter and strobe decode.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    pulse_s = 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
    rel_pulse_s = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (sync_btn_s) begin
          state_s = ARMING;
          cnt_s   = CNT_ONE;
        end else begin
          cnt_s   = CNT_ZERO;
        end
      end
      ARMING: begin
        if (!sync_btn_s) begin
          // Bounce: fall back silently.
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r >= CNT_LAST) begin
          state_s = HELD;
          cnt_s   = CNT_ZERO;
          pulse_s = 1'b1;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      HELD: begin
        if (!sync_btn_s) begin
          state_s = RELEASING;
          cnt_s   = CNT_ONE;
        end else begin
          cnt_s   = CNT_ZERO;
        end
      end
      RELEASING: begin
        if (sync_btn_s) begin
          // Release glitch: still pressed, no new press strobe.
          state_s = HELD;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r >= CNT_LAST) begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
`ifdef BTN_RELEASE_PULSE_EN
          rel_pulse_s = 1'b1;
`endif
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
    held_s = is_held_state(state_s);
  end

  // State, counter and registered outputs; reset aborts any debounce in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      pulse_r <= 1'b0;
      held_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      pulse_r <= pulse_s;
      held_r  <= held_s;
    end
  end

`ifdef BTN_RELEASE_PULSE_EN
  // Registered strobe for each confirmed release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rel_pulse_r <= 1'b0;
    end else begin
      rel_pulse_r <= rel_pulse_s;
    end
  end

  assign rel_pulse = rel_pulse_r;
`endif

  assign pulse = pulse_r;
  assign held  = held_r;

endmodule

// File: tb/tb_button_sync_pulse.sv
// Self-checking bench for button_sync_pulse (DEBOUNCE_CYCLES = 4).
// Expected outputs are queued per clock edge when stimulus is applied and
// compared by a monitor #1 after each rising edge.
module tb_button_sync_pulse;

  localparam int D   = 4;
  localparam int LAT = D + 2;  // edges from btn change to output change

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn = 1'b0;
  logic pulse;
  logic held;
`ifdef BTN_RELEASE_PULSE_EN
  logic rel_pulse;
`endif

  int   errors    = 0;
  int   checks    = 0;
  int   cyc       = 0;
  int   pulse_cnt = 0;
  logic prev_pulse = 1'b0;

  typedef struct {
    int    c;
    logic  p;
    logic  h;
    logic  r;
    string nm;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  button_sync_pulse #(.DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
`ifdef BTN_RELEASE_PULSE_EN
    .rel_pulse (rel_pulse),
`endif
    .pulse     (pulse),
    .held      (held)
  );

  initial forever #5 clk = ~clk;

  // Monitor: count edges, pop due expectations, compare outputs.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (pulse === 1'b1) begin
      pulse_cnt = pulse_cnt + 1;
      checks    = checks + 1;
      if (prev_pulse === 1'b1) begin
        errors = errors + 1;
        $display("FAIL pulse_width cyc=%0d: pulse high two cycles in a row, need single cycle", cyc);
      end
    end
    prev_pulse = pulse;
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      e = sb.pop_front();
      checks = checks + 1;
      if (e.c != cyc) begin
        errors = errors + 1;
        $display("FAIL %s: expectation for cyc %0d missed (now %0d)", e.nm, e.c, cyc);
      end else if (pulse !== e.p || held !== e.h) begin
        errors = errors + 1;
        $display("FAIL %s cyc=%0d: pulse=%b held=%b, need pulse=%b held=%b",
                 e.nm, cyc, pulse, held, e.p, e.h);
      end
`ifdef BTN_RELEASE_PULSE_EN
      checks = checks + 1;
      if (rel_pulse !== e.r) begin
        errors = errors + 1;
        $display("FAIL %s_rel cyc=%0d: rel_pulse=%b, need %b", e.nm, cyc, rel_pulse, e.r);
      end
`endif
    end
  end

  function automatic void push_exp(int c, logic p, logic h, logic r, string nm);
    exp_t x;
    x.c = c; x.p = p; x.h = h; x.r = r; x.nm = nm;
    sb.push_back(x);
  endfunction

  // Press applied before edge n+1: pulse after edge n+LAT, held from then on.
  function automatic void exp_press(int n, string nm);
    for (int k = 1; k <= LAT + 1; k++)
      push_exp(n + k, (k == LAT), (k >= LAT), 1'b0, nm);
  endfunction

  // Release applied before edge m+1: held drops and rel strobes after edge m+LAT.
  function automatic void exp_release(int m, string nm);
    for (int k = 1; k <= LAT + 1; k++)
      push_exp(m + k, 1'b0, (k < LAT), (k == LAT), nm);
  endfunction

  task automatic wait_drain(input int budget, output bit ok);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (sb.size() == 0);
    if (!ok) sb.delete();
  endtask

  task automatic test_reset();
    int n, m, p0;
    bit ok;
    rst = 1'b0;
    btn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (pulse !== 1'b0 || held !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: pulse=%b held=%b, need 0 0", pulse, held);
      end
    end
    p0 = pulse_cnt;
    n = cyc;
    rst = 1'b1;
    exp_press(n, "reset_release");
    wait_drain(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_release_timeout: queue not drained, need drained"); end
    repeat (4) @(negedge clk);
    checks++;
    if (pulse_cnt != p0 + 1) begin
      errors++;
      $display("FAIL reset_pulse_count: got %0d pulses, need 1", pulse_cnt - p0);
    end
    m = cyc;
    btn = 1'b0;
    exp_release(m, "reset_release_up");
    wait_drain(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_up_timeout: queue not drained, need drained"); end
  endtask

  task automatic test_clean_press();
    int n, m, p0;
    bit ok;
    @(negedge clk);
    n = cyc;
    p0 = pulse_cnt;
    btn = 1'b1;
    for (int k = 1; k <= 20; k++)
      push_exp(n + k, (k == LAT), (k >= LAT), 1'b0, "clean_press");
    repeat (20) @(negedge clk);
    m = cyc;
    btn = 1'b0;
    exp_release(m, "clean_release");
    wait_drain(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clean_timeout: queue not drained, need drained"); end
    checks++;
    if (pulse_cnt != p0 + 1) begin
      errors++;
      $display("FAIL clean_pulse_count: got %0d pulses, need 1", pulse_cnt - p0);
    end
  endtask

  task automatic test_bounce();
    int n, m;
    bit ok;
    @(negedge clk);
    n = cyc;
    for (int k = 1; k <= 12; k++)
      push_exp(n + k, 1'b0, 1'b0, 1'b0, "bounce");
    btn = 1'b1; repeat (2) @(negedge clk);
    btn = 1'b0; repeat (1) @(negedge clk);
    btn = 1'b1; repeat (2) @(negedge clk);
    btn = 1'b0;
    wait_drain(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bounce_timeout: queue not drained, need drained"); end
    // Exact press latency afterwards shows the FSM is back in IDLE with cnt=0.
    n = cyc;
    btn = 1'b1;
    exp_press(n, "bounce_then_press");
    wait_drain(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bounce_press_timeout: queue not drained, need drained"); end
    m = cyc;
    btn = 1'b0;
    exp_release(m, "bounce_then_release");
    wait_drain(40, ok);
  endtask

  task automatic test_release_glitch();
    int n, m, p0;
    bit ok;
    @(negedge clk);
    n = cyc;
    p0 = pulse_cnt;
    btn = 1'b1;
    exp_press(n, "glitch_press");
    wait_drain(40, ok);
    m = cyc;
    btn = 1'b0;
    for (int k = 1; k <= 12; k++)
      push_exp(m + k, 1'b0, 1'b1, 1'b0, "release_glitch");
    repeat (2) @(negedge clk);
    btn = 1'b1;
    wait_drain(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL glitch_timeout: queue not drained, need drained"); end
    checks++;
    if (pulse_cnt != p0 + 1) begin
      errors++;
      $display("FAIL glitch_pulse_count: got %0d pulses, need 1", pulse_cnt - p0);
    end
    m = cyc;
    btn = 1'b0;
    exp_release(m, "glitch_release");
    wait_drain(40, ok);
  endtask

  task automatic test_mid_reset();
    int n, p, m, p0;
    bit ok;
    @(negedge clk);
    n = cyc;
    p0 = pulse_cnt;
    btn = 1'b1;
    repeat (4) @(negedge clk);  // ARMING with cnt=2
    rst = 1'b0;
    #1;
    checks++;
    if (pulse !== 1'b0 || held !== 1'b0) begin
      errors++;
      $display("FAIL midreset_immediate: pulse=%b held=%b, need 0 0", pulse, held);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (pulse !== 1'b0 || held !== 1'b0) begin
        errors++;
        $display("FAIL midreset_hold: pulse=%b held=%b, need 0 0", pulse, held);
      end
    end
    checks++;
    if (pulse_cnt != p0) begin
      errors++;
      $display("FAIL midreset_abort: got %0d pulses, need 0", pulse_cnt - p0);
    end
    p = cyc;
    rst = 1'b1;
    exp_press(p, "midreset_redebounce");
    wait_drain(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midreset_timeout: queue not drained, need drained"); end
    checks++;
    if (pulse_cnt != p0 + 1) begin
      errors++;
      $display("FAIL midreset_pulse_count: got %0d pulses, need 1", pulse_cnt - p0);
    end
    m = cyc;
    btn = 1'b0;
    exp_release(m, "midreset_release");
    wait_drain(40, ok);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_mid_reset();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, need completion");
    $fatal(1, "watchdog");
  end

endmodule
